// File: rtl/bytecode_pkg.sv
// Shared definitions for the bytecode fetch front end: opcode values,
// fetch state encoding and the operand-length rule.
package bytecode_pkg;

   localparam logic [7:0] ICONST_0 = 8'h03;
   localparam logic [7:0] ICONST_1 = 8'h04;
   localparam logic [7:0] BIPUSH   = 8'h10;
   localparam logic [7:0] SIPUSH   = 8'h11;
   localparam logic [7:0] LDC      = 8'h12;
   localparam logic [7:0] ILOAD    = 8'h15;
   localparam logic [7:0] ISTORE   = 8'h36;
   localparam logic [7:0] IINC     = 8'h84;
   localparam logic [7:0] IFEQ     = 8'h99;
   localparam logic [7:0] IFNE     = 8'h9A;
   localparam logic [7:0] GOTO     = 8'hA7;
   localparam logic [7:0] DDIV     = 8'h6F;
   localparam logic [7:0] I2B      = 8'h91;
   localparam logic [7:0] LASTORE  = 8'h50;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REQ_OP   = 3'd1,
      ST_WAIT_OP  = 3'd2,
      ST_REQ_ARG  = 3'd3,
      ST_WAIT_ARG = 3'd4,
      ST_ISSUE    = 3'd5
   } fetch_state_t;

   // Number of operand bytes that follow an opcode (0..2).
   function automatic logic [1:0] operand_length(input logic [7:0] opcode);
      logic [1:0] len_v;
      case (opcode)
         BIPUSH, LDC, ILOAD, ISTORE:       len_v = 2'd1;
         SIPUSH, IINC, IFEQ, IFNE, GOTO:   len_v = 2'd2;
         default:                          len_v = 2'd0;
      endcase
      return len_v;
   endfunction

endpackage

// File: rtl/opcode_length_lut.sv
// Combinational opcode to operand-length decoder.
module opcode_length_lut
   import bytecode_pkg::*;
(
   input  logic [7:0] opcode,
   output logic [1:0] length
);

   // Look up the operand byte count of the incoming opcode
   always_comb begin
      length = operand_length(opcode);
   end

endmodule

// File: rtl/bytecode_fetch_sequencer.sv
// Fetch sequencer: reads opcode and operand bytes from program memory,
// assembles the instruction and hands it to the decoder. Owns the PC.
module bytecode_fetch_sequencer
   import bytecode_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_gnt,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  start_for_decoder,
   input  logic                  ready_from_decoder,
   output logic [7:0]            opcode_for_decoder,
   output logic [15:0]           operand_for_decoder,
   output logic [1:0]            operand_count,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  branch_valid,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic                  busy
);

   localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   fetch_state_t          state_r, state_nxt_s;
   logic [ADDR_WIDTH-1:0] pc_r, pc_nxt_s;
   logic [1:0]            remaining_r, remaining_nxt_s;
   logic [7:0]            opcode_r, opcode_nxt_s;
   logic [15:0]           operand_r, operand_nxt_s;
   logic [1:0]            count_r, count_nxt_s;
   logic [ADDR_WIDTH-1:0] instr_pc_r, instr_pc_nxt_s;
   logic                  mem_req_r, mem_req_nxt_s;
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic                  start_r;
   logic                  busy_r;
   logic [1:0]            lut_len_s;
   logic [7:0]            rbyte_s;

   assign rbyte_s = mem_rdata[7:0];

   opcode_length_lut u_lut (
      .opcode (rbyte_s),
      .length (lut_len_s)
   );

   // Next-state, PC and instruction-field computation
   always_comb begin
      state_nxt_s     = state_r;
      pc_nxt_s        = pc_r;
      remaining_nxt_s = remaining_r;
      opcode_nxt_s    = opcode_r;
      operand_nxt_s   = operand_r;
      count_nxt_s     = count_r;
      instr_pc_nxt_s  = instr_pc_r;
      case (state_r)
         ST_IDLE: begin
            if (branch_valid) begin
               pc_nxt_s = branch_target;
            end else if (enable) begin
               state_nxt_s = ST_REQ_OP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ_OP: begin
            if (branch_valid) begin
               pc_nxt_s    = branch_target;
               state_nxt_s = ST_REQ_OP;
            end else if (mem_gnt) begin
               pc_nxt_s       = pc_r + PC_ONE;
               instr_pc_nxt_s = pc_r;
               state_nxt_s    = ST_WAIT_OP;
            end else begin
               state_nxt_s = ST_REQ_OP;
            end
         end
         ST_WAIT_OP: begin
            if (branch_valid) begin
               pc_nxt_s    = branch_target;
               state_nxt_s = ST_REQ_OP;
            end else begin
               opcode_nxt_s    = rbyte_s;
               remaining_nxt_s = lut_len_s;
               count_nxt_s     = lut_len_s;
               operand_nxt_s   = 16'h0000;
               state_nxt_s     = (lut_len_s == 2'd0) ? ST_ISSUE : ST_REQ_ARG;
            end
         end
         ST_REQ_ARG: begin
            if (branch_valid) begin
               pc_nxt_s    = branch_target;
               state_nxt_s = ST_REQ_OP;
            end else if (mem_gnt) begin
               pc_nxt_s    = pc_r + PC_ONE;
               state_nxt_s = ST_WAIT_ARG;
            end else begin
               state_nxt_s = ST_REQ_ARG;
            end
         end
         ST_WAIT_ARG: begin
            if (branch_valid) begin
               pc_nxt_s    = branch_target;
               state_nxt_s = ST_REQ_OP;
            end else begin
               // Big-endian: the first of two operand bytes is the high byte
               if ((count_r == 2'd2) && (remaining_r == 2'd2)) begin
                  operand_nxt_s[15:8] = rbyte_s;
               end else begin
                  operand_nxt_s[7:0] = rbyte_s;
               end
               remaining_nxt_s = remaining_r - 2'd1;
               state_nxt_s     = (remaining_r == 2'd1) ? ST_ISSUE : ST_REQ_ARG;
            end
         end
         ST_ISSUE: begin
            if (branch_valid) begin
               pc_nxt_s    = branch_target;
               state_nxt_s = ST_REQ_OP;
            end else if (ready_from_decoder) begin
               state_nxt_s = enable ? ST_REQ_OP : ST_IDLE;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      mem_req_nxt_s = (state_nxt_s == ST_REQ_OP) || (state_nxt_s == ST_REQ_ARG);
   end

   // State, PC, instruction fields and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         pc_r        <= RESET_PC;
         remaining_r <= 2'd0;
         opcode_r    <= 8'h00;
         operand_r   <= 16'h0000;
         count_r     <= 2'd0;
         instr_pc_r  <= {ADDR_WIDTH{1'b0}};
         mem_req_r   <= 1'b0;
         mem_addr_r  <= {ADDR_WIDTH{1'b0}};
         start_r     <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         pc_r        <= pc_nxt_s;
         remaining_r <= remaining_nxt_s;
         opcode_r    <= opcode_nxt_s;
         operand_r   <= operand_nxt_s;
         count_r     <= count_nxt_s;
         instr_pc_r  <= instr_pc_nxt_s;
         mem_req_r   <= mem_req_nxt_s;
         mem_addr_r  <= mem_req_nxt_s ? pc_nxt_s : mem_addr_r;
         start_r     <= (state_nxt_s == ST_ISSUE);
         busy_r      <= (state_nxt_s != ST_IDLE);
      end
   end

   assign mem_req             = mem_req_r;
   assign mem_addr            = mem_addr_r;
   assign start_for_decoder   = start_r;
   assign opcode_for_decoder  = opcode_r;
   assign operand_for_decoder = operand_r;
   assign operand_count       = count_r;
   assign instr_pc            = instr_pc_r;
   assign busy                = busy_r;

endmodule

// File: tb/tb_bytecode_fetch_sequencer.sv
// Self-checking bench for bytecode_fetch_sequencer: opcode vector table,
// hand-written corner sequences and a randomized run against a program model.
module tb_bytecode_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        mem_gnt;
   logic [7:0]  mem_rdata = 8'h00;
   logic        start_for_decoder;
   logic        ready_from_decoder;
   logic [7:0]  opcode_for_decoder;
   logic [15:0] operand_for_decoder;
   logic [1:0]  operand_count;
   logic [7:0]  instr_pc;
   logic        branch_valid;
   logic [7:0]  branch_target;
   logic        busy;

   logic [7:0]  mem [256];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [7:0]  op;
      logic [15:0] opnd;
      logic [1:0]  cnt;
      logic [7:0]  pc;
      int          cyc;
   } tr_t;
   typedef struct {
      logic [7:0] addr;
      int         cyc;
   } gr_t;
   typedef struct {
      logic [7:0]  b0, b1, b2;
      logic [1:0]  cnt;
      logic [15:0] opnd;
   } vec_t;

   tr_t  tr_q[$];
   gr_t  gr_q[$];
   vec_t vecs[14];

   bytecode_fetch_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RESET_PC(8'h00)) dut (
      .clk                 (clk),
      .reset               (reset),
      .enable              (enable),
      .mem_req             (mem_req),
      .mem_addr            (mem_addr),
      .mem_gnt             (mem_gnt),
      .mem_rdata           (mem_rdata),
      .start_for_decoder   (start_for_decoder),
      .ready_from_decoder  (ready_from_decoder),
      .opcode_for_decoder  (opcode_for_decoder),
      .operand_for_decoder (operand_for_decoder),
      .operand_count       (operand_count),
      .instr_pc            (instr_pc),
      .branch_valid        (branch_valid),
      .branch_target       (branch_target),
      .busy                (busy)
   );

   always #5 clk = ~clk;

   // Program memory: data returned the cycle after a granted request
   always @(posedge clk) begin
      if (mem_req && mem_gnt) mem_rdata <= mem[mem_addr];
      else                    mem_rdata <= 8'hEE;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; mem_gnt = 1'b0; ready_from_decoder = 1'b0;
      branch_valid = 1'b0; branch_target = 8'h00;
      repeat (2) @(negedge clk);
      check("reset_outputs", {mem_req, start_for_decoder, busy, operand_count, mem_addr,
            opcode_for_decoder, operand_for_decoder, instr_pc}, 64'd0);
      reset = 1'b0;
   endtask

   task automatic wait_start(input string name, input int budget);
      int n = 0;
      while (!start_for_decoder && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!start_for_decoder) begin
         checks++; errors++;
         $display("FAIL %s: start_for_decoder got 0 within %0d cycles, expected 1", name, budget);
      end
   endtask

   task automatic collect(input int n);
      tr_t t;
      gr_t g;
      repeat (n) begin
         @(negedge clk);
         cyc++;
         if (start_for_decoder && ready_from_decoder) begin
            t.op = opcode_for_decoder; t.opnd = operand_for_decoder;
            t.cnt = operand_count; t.pc = instr_pc; t.cyc = cyc;
            tr_q.push_back(t);
         end
         if (mem_req && mem_gnt) begin
            g.addr = mem_addr; g.cyc = cyc;
            gr_q.push_back(g);
         end
      end
   endtask

   // Reference program walk: operand count by opcode class
   function automatic int ref_len(input logic [7:0] op);
      if (op inside {8'h10, 8'h12, 8'h15, 8'h36}) return 1;
      if (op inside {8'h11, 8'h84, 8'h99, 8'h9A, 8'hA7}) return 2;
      return 0;
   endfunction

   initial begin
      logic        prev_req, prev_gnt, prev_start, prev_ready;
      logic [7:0]  prev_addr;
      logic [33:0] prev_instr;
      logic [7:0]  mpc, eop;
      logic [15:0] eopnd;
      int          len, n_tr, viol, k;

      vecs[0]  = '{8'h03, 8'h11, 8'h22, 2'd0, 16'h0000};
      vecs[1]  = '{8'h04, 8'h11, 8'h22, 2'd0, 16'h0000};
      vecs[2]  = '{8'h10, 8'h7F, 8'h22, 2'd1, 16'h007F};
      vecs[3]  = '{8'h11, 8'h12, 8'h34, 2'd2, 16'h1234};
      vecs[4]  = '{8'h12, 8'hAB, 8'h22, 2'd1, 16'h00AB};
      vecs[5]  = '{8'h15, 8'h05, 8'h22, 2'd1, 16'h0005};
      vecs[6]  = '{8'h36, 8'hFF, 8'h22, 2'd1, 16'h00FF};
      vecs[7]  = '{8'h84, 8'h01, 8'hFF, 2'd2, 16'h01FF};
      vecs[8]  = '{8'h99, 8'h80, 8'h01, 2'd2, 16'h8001};
      vecs[9]  = '{8'h9A, 8'hFF, 8'hFE, 2'd2, 16'hFFFE};
      vecs[10] = '{8'hA7, 8'h00, 8'h08, 2'd2, 16'h0008};
      vecs[11] = '{8'h6F, 8'h11, 8'h22, 2'd0, 16'h0000};
      vecs[12] = '{8'h91, 8'h11, 8'h22, 2'd0, 16'h0000};
      vecs[13] = '{8'h50, 8'h11, 8'h22, 2'd0, 16'h0000};

      // Opcode table: each opcode issued with its operand count and operands
      for (int v = 0; v < 14; v++) begin
         do_reset();
         clear_mem();
         mem[0] = vecs[v].b0; mem[1] = vecs[v].b1; mem[2] = vecs[v].b2;
         enable = 1'b1; mem_gnt = 1'b1; ready_from_decoder = 1'b0;
         wait_start($sformatf("vec%0d_start", v), 20);
         check($sformatf("vec%0d_opcode", v),  opcode_for_decoder,  vecs[v].b0);
         check($sformatf("vec%0d_operand", v), operand_for_decoder, vecs[v].opnd);
         check($sformatf("vec%0d_count", v),   operand_count,       vecs[v].cnt);
         check($sformatf("vec%0d_pc", v),      instr_pc,            8'h00);
         ready_from_decoder = 1'b1; enable = 1'b0;
         @(negedge clk);
         ready_from_decoder = 1'b0;
         repeat (2) @(negedge clk);
         check($sformatf("vec%0d_idle", v), {busy, start_for_decoder}, 2'b00);
      end

      // Two zero-operand opcodes back to back, first-start latency
      do_reset(); clear_mem();
      mem[0] = 8'h03; mem[1] = 8'h04;
      tr_q.delete(); gr_q.delete(); cyc = 0;
      enable = 1'b1; mem_gnt = 1'b1; ready_from_decoder = 1'b1;
      collect(12);
      if (tr_q.size() >= 2 && gr_q.size() >= 1) begin
         check("seq1_op0", tr_q[0].op, 8'h03);
         check("seq1_pc0", tr_q[0].pc, 8'h00);
         check("seq1_cnt0", tr_q[0].cnt, 2'd0);
         check("seq1_op1", tr_q[1].op, 8'h04);
         check("seq1_pc1", tr_q[1].pc, 8'h01);
         check("seq1_cnt1", tr_q[1].cnt, 2'd0);
         check("seq1_latency", tr_q[0].cyc - gr_q[0].cyc, 2);
      end else begin
         check("seq1_transfers", tr_q.size(), 2);
      end

      // bipush then sipush, PC continues at 5
      do_reset(); clear_mem();
      mem[0] = 8'h10; mem[1] = 8'h7F; mem[2] = 8'h11; mem[3] = 8'h12; mem[4] = 8'h34;
      tr_q.delete(); gr_q.delete(); cyc = 0;
      enable = 1'b1; mem_gnt = 1'b1; ready_from_decoder = 1'b1;
      collect(20);
      if (tr_q.size() >= 2 && gr_q.size() >= 6) begin
         check("seq2_bipush", {tr_q[0].op, tr_q[0].opnd, tr_q[0].cnt, tr_q[0].pc},
               {8'h10, 16'h007F, 2'd1, 8'h00});
         check("seq2_sipush", {tr_q[1].op, tr_q[1].opnd, tr_q[1].cnt, tr_q[1].pc},
               {8'h11, 16'h1234, 2'd2, 8'h02});
         check("seq2_next_addr", gr_q[5].addr, 8'h05);
      end else begin
         check("seq2_transfers", tr_q.size(), 2);
      end

      // Decoder stall: instruction held stable, single transfer
      do_reset(); clear_mem();
      mem[0] = 8'h6F;
      enable = 1'b1; mem_gnt = 1'b1; ready_from_decoder = 1'b0;
      wait_start("seq3_start", 20);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("seq3_hold%0d", i), {start_for_decoder, opcode_for_decoder, instr_pc},
               {1'b1, 8'h6F, 8'h00});
         @(negedge clk);
      end
      ready_from_decoder = 1'b1;
      @(negedge clk);
      ready_from_decoder = 1'b0;
      check("seq3_start_drop", start_for_decoder, 1'b0);
      check("seq3_next_req", {mem_req, mem_addr}, {1'b1, 8'h01});

      // Grant stall during operand fetch
      do_reset(); clear_mem();
      mem[0] = 8'hA7; mem[1] = 8'h00; mem[2] = 8'h08;
      enable = 1'b1; mem_gnt = 1'b1; ready_from_decoder = 1'b0;
      k = 0;
      while (!(mem_req && mem_addr == 8'h01) && k < 20) begin
         @(negedge clk);
         k++;
      end
      mem_gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("seq4_stall%0d", i), {mem_req, mem_addr}, {1'b1, 8'h01});
         @(negedge clk);
      end
      mem_gnt = 1'b1;
      wait_start("seq4_start", 20);
      check("seq4_operand", {operand_for_decoder, operand_count}, {16'h0008, 2'd2});

      // Branch during operand fetch drops the sipush
      do_reset(); clear_mem();
      mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h34; mem[8'h20] = 8'h03;
      enable = 1'b1; mem_gnt = 1'b1; ready_from_decoder = 1'b0;
      k = 0;
      while (!(mem_req && mem_gnt && mem_addr == 8'h01) && k < 20) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      branch_valid = 1'b1; branch_target = 8'h20;
      @(negedge clk);
      branch_valid = 1'b0;
      check("seq5_redirect", {mem_req, mem_addr, start_for_decoder}, {1'b1, 8'h20, 1'b0});
      wait_start("seq5_start", 20);
      check("seq5_after", {opcode_for_decoder, instr_pc}, {8'h03, 8'h20});

      // Branch together with ready in ISSUE
      do_reset(); clear_mem();
      mem[0] = 8'h03; mem[8'h20] = 8'h04;
      enable = 1'b1; mem_gnt = 1'b1; ready_from_decoder = 1'b0;
      wait_start("seq5b_start", 20);
      ready_from_decoder = 1'b1; branch_valid = 1'b1; branch_target = 8'h20;
      @(negedge clk);
      ready_from_decoder = 1'b0; branch_valid = 1'b0;
      check("seq5b_redirect", {start_for_decoder, mem_req, mem_addr}, {1'b0, 1'b1, 8'h20});
      wait_start("seq5b_next", 20);
      check("seq5b_after", {opcode_for_decoder, instr_pc}, {8'h04, 8'h20});

      // PC wrap: bipush at FF takes its operand from 00
      do_reset(); clear_mem();
      mem[8'hFF] = 8'h10; mem[8'h00] = 8'h05;
      branch_valid = 1'b1; branch_target = 8'hFF;
      @(negedge clk);
      branch_valid = 1'b0;
      check("seq6_idle_branch", busy, 1'b0);
      enable = 1'b1; mem_gnt = 1'b1; ready_from_decoder = 1'b0;
      wait_start("seq6_start", 20);
      check("seq6_instr", {opcode_for_decoder, operand_for_decoder, operand_count, instr_pc},
            {8'h10, 16'h0005, 2'd1, 8'hFF});
      ready_from_decoder = 1'b1;
      @(negedge clk);
      ready_from_decoder = 1'b0;
      check("seq6_wrap_addr", {mem_req, mem_addr}, {1'b1, 8'h01});

      // Asynchronous reset during WAIT_OP, then restart from RESET_PC
      do_reset(); clear_mem();
      mem[0] = 8'h10; mem[1] = 8'h55;
      enable = 1'b1; mem_gnt = 1'b1; ready_from_decoder = 1'b1;
      k = 0;
      while (!(mem_req && mem_gnt) && k < 20) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      check("seq7_busy", busy, 1'b1);
      #2 reset = 1'b1;
      #1 check("seq7_async_reset", {mem_req, start_for_decoder, busy, operand_count, mem_addr,
               opcode_for_decoder, operand_for_decoder, instr_pc}, 64'd0);
      @(negedge clk);
      reset = 1'b0; enable = 1'b1; mem_gnt = 1'b1; ready_from_decoder = 1'b0;
      wait_start("seq7_restart", 20);
      check("seq7_restart_instr", {opcode_for_decoder, operand_for_decoder, instr_pc},
            {8'h10, 16'h0055, 8'h00});

      // Randomized program, grants and decoder readiness against the program walk
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
      enable = 1'b1; mem_gnt = 1'b0; ready_from_decoder = 1'b0;
      prev_req = 1'b0; prev_gnt = 1'b0; prev_start = 1'b0; prev_ready = 1'b0;
      prev_addr = 8'h00; prev_instr = 34'd0;
      mpc = 8'h00; n_tr = 0; viol = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (prev_req && !prev_gnt && !(mem_req && mem_addr == prev_addr)) viol++;
         if (prev_start && !prev_ready && !(start_for_decoder &&
             {opcode_for_decoder, operand_for_decoder, operand_count, instr_pc} == prev_instr)) viol++;
         mem_gnt = ($urandom_range(0, 9) < 6);
         ready_from_decoder = 1'($urandom_range(0, 1));
         if (start_for_decoder && ready_from_decoder) begin
            eop = mem[mpc];
            len = ref_len(eop);
            if (len == 1)      eopnd = {8'h00, mem[8'(mpc + 8'd1)]};
            else if (len == 2) eopnd = {mem[8'(mpc + 8'd1)], mem[8'(mpc + 8'd2)]};
            else               eopnd = 16'h0000;
            check($sformatf("rand_tr%0d", n_tr),
                  {opcode_for_decoder, operand_for_decoder, operand_count, instr_pc},
                  {eop, eopnd, 2'(len), mpc});
            mpc = 8'(mpc + 8'(len) + 8'd1);
            n_tr++;
         end
         prev_req = mem_req; prev_gnt = mem_gnt; prev_addr = mem_addr;
         prev_start = start_for_decoder; prev_ready = ready_from_decoder;
         prev_instr = {opcode_for_decoder, operand_for_decoder, operand_count, instr_pc};
      end
      check("rand_protocol_violations", viol, 0);
      check("rand_enough_transfers", (n_tr > 100), 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bytecode_fetch_sequencer.md
Name: bytecode_fetch_sequencer

Overview:
- Front-end controller between byte-wide program memory and the opcode decoder.
- Fetches an opcode byte, looks up its operand length and fetches 0–2 operand bytes over a request/grant memory port shared with decoder data accesses.
- Presents the assembled instruction to the decoder with a start/ready handshake and redirects the PC on branches.
- Successor to the single-byte opcode fetch FSM; owns the program counter.

Parameters:
- ADDR_WIDTH, 8, program memory address width; PC wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 8, memory data width (one bytecode byte).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  high = fetch new instructions; low = finish the current instruction, then idle.
- mem_req  out  1  memory read request, held until granted.
- mem_addr  out  ADDR_WIDTH  read address, stable while mem_req is high.
- mem_gnt  in  1  request accepted this cycle; read data is valid on the next cycle.
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_req && mem_gnt.
- start_for_decoder  out  1  instruction valid, held until ready_from_decoder.
- ready_from_decoder  in  1  decoder accepts; transfer occurs when start_for_decoder && ready_from_decoder.
- opcode_for_decoder  out  8  opcode byte.
- operand_for_decoder  out  16  assembled operands.
- operand_count  out  2  number of operand bytes (0..2).
- instr_pc  out  ADDR_WIDTH  address of the opcode byte.
- branch_valid  in  1  one-cycle redirect pulse from the decoder.
- branch_target  in  ADDR_WIDTH  new PC when branch_valid is high.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: PC=RESET_PC, state=IDLE, and every output 0 (mem_req, mem_addr, start_for_decoder, opcode_for_decoder, operand_for_decoder, operand_count, instr_pc, busy).
- States: IDLE, REQ_OP, WAIT_OP, REQ_ARG, WAIT_ARG, ISSUE.
- IDLE: if enable, go to REQ_OP.
- REQ_OP: mem_req=1, mem_addr=PC.
  - On mem_gnt: PC<=PC+1, instr_pc<=PC, go to WAIT_OP.
- WAIT_OP:
  - Capture mem_rdata into the opcode register.
  - Set remaining = LUT(opcode) and clear operand_for_decoder.
  - If remaining=0 go to ISSUE, else go to REQ_ARG.
- REQ_ARG: mem_req=1, mem_addr=PC; on mem_gnt PC<=PC+1, go to WAIT_ARG.
- WAIT_ARG:
  - 1-operand opcode: byte goes to operand_for_decoder[7:0], and [15:8]=0.
  - 2-operand opcode, big-endian: first byte to [15:8], second to [7:0].
  - Decrement remaining. If it reaches 0 go to ISSUE, else go to REQ_ARG.
- ISSUE: start_for_decoder=1 with stable opcode, operands, count and instr_pc.
  - On ready_from_decoder: go to REQ_OP if enable, else IDLE; start deasserts next cycle.
- Operand LUT (hex):
  - 1 operand: 10 bipush, 12 ldc, 15 iload, 36 istore.
  - 2 operands: 11 sipush, 84 iinc, 99 ifeq, 9A ifne, A7 goto.
  - All other opcodes: 0 operands.
- Latency: grant in cycle N → opcode captured N+1 → start high N+2 (0 operands). Each operand byte adds at least 2 cycles. No prefetch.
- Grant stalls: mem_req stays high with unchanged mem_addr for any number of cycles.
- PC arithmetic: ADDR_WIDTH-bit modulo. PC=FF (8-bit) increments to 00, and operand fetch continues across the wrap.
- Redirect (branch_valid), any state except IDLE:
  - PC<=branch_target, go to REQ_OP next cycle.
  - Any granted in-flight read is discarded (its WAIT_* cycle is squashed).
  - Partial operands are dropped.
- Redirect in ISSUE:
  - Without ready: the instruction is dropped and start deasserts next cycle.
  - Together with ready: the transfer completes AND the redirect is taken.
- branch_valid in IDLE: PC<=branch_target, state stays IDLE.
- Simultaneous mem_gnt and branch_valid: the branch wins and the PC increment is suppressed.
- enable low mid-instruction: the current instruction completes through ISSUE, then the FSM goes to IDLE.
- Reset mid-operation: immediate return to the reset values; the in-flight memory response is ignored.

Decomposition:
- Shared package bytecode_pkg holds:
  - opcode localparams: ICONST_0=03, ICONST_1=04, BIPUSH=10, SIPUSH=11, LDC=12, ILOAD=15, ISTORE=36, IINC=84, IFEQ=99, IFNE=9A, GOTO=A7, DDIV=6F, I2B=91, LASTORE=50;
  - the fetch state encoding (3 bits);
  - the operand-length function.
- One sub-module: opcode_length_lut (8-bit opcode in, 2-bit length out, combinational).

Test Plan:
- Memory 03,04 at addr 0, mem_gnt tied 1, ready tied 1 → issues opcode 03 then 04, both count 0, instr_pc 0 then 1; first start exactly 2 cycles after the first grant.
- Memory 10,7F,11,12,34 → bipush with operand 007F, count 1, instr_pc 0; then sipush with operand 1234, count 2, instr_pc 2; PC ends at 5.
- Opcode 6F issued with ready low for 5 cycles, then high → start, opcode 6F and instr_pc 0 stable all 5 cycles; one transfer only; next mem_req the cycle after the transfer.
- mem_gnt low for 4 cycles during an operand fetch of A7,00,08 → mem_req and mem_addr held at 1; operand_for_decoder=0008 once granted.
- branch_valid with target 20 while in WAIT_ARG of sipush → operand dropped, no start, next mem_addr=20; a second case with branch and ready together in ISSUE → one transfer and next mem_addr=20.
- PC=FF with memory FF=10, 00=05 → operand 0005, PC wraps to 01. Reset asserted in WAIT_OP → all outputs 0 asynchronously; restart fetches from RESET_PC.
